uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of payload bits per frame; SHALL equal the parity block's p_data width.
REQ-002 clk  input  1  bit clock; one tx_out bit period per rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 p_data  input  DATA_WIDTH  byte to transmit, valid while data_valid=1.
REQ-005 data_valid  input  1  single-cycle request to send p_data.
REQ-006 par_en  input  1  1 = frame carries a parity bit.
REQ-007 par_typ  input  1  1 = odd, 0 = even; informational only, latched for status.
REQ-008 par_bit  input  1  parity of p_data, computed combinationally by the upstream parity block from p_data, data_valid and par_typ.
REQ-009 tx_out  output  1  serial line, idle high, registered.
REQ-010 busy  output  1  1 while a frame is on the line, registered.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP; each bit state lasts exactly one clk cycle, except DATA, which lasts DATA_WIDTH cycles.
REQ-012 Acceptance: data_valid=1 sampled at a rising edge while in IDLE or STOP SHALL latch p_data, par_bit, par_en and par_typ and enter START at that edge.
REQ-013 data_valid in START, DATA or PARITY SHALL be ignored; no queuing and no corruption of the frame in progress.
REQ-014 START drives tx_out=0; latency from accepting edge to start bit is 0 cycles (start bit visible in the cycle after the accepting edge).
REQ-015 DATA drives latched bits LSB first; a bit counter 0..DATA_WIDTH-1 advances each cycle, and exit occurs on count DATA_WIDTH-1.
REQ-016 After DATA, the next state is PARITY if latched par_en=1, else STOP.
REQ-017 PARITY drives the latched par_bit, not the live input.
REQ-018 STOP drives tx_out=1; the next state is START if data_valid=1 (back-to-back, no idle gap), else IDLE.
REQ-019 Frame length SHALL be 11 cycles with parity and 10 without (DATA_WIDTH=8).
REQ-020 IDLE drives tx_out=1, busy=0; busy=1 in START, DATA, PARITY and STOP.
REQ-021 Illegal state encodings SHALL recover to IDLE on the next edge with tx_out=1.

Reset
REQ-022 rst=0 SHALL immediately force state=IDLE, tx_out=1, busy=0, bit counter=0, and latched data/parity/config=0, regardless of clk.
REQ-023 Reset mid-frame SHALL abort the frame; after rst rises, the first accepted data_valid starts a fresh frame with no residue.
REQ-024 data_valid asserted in the same cycle rst deasserts SHALL be ignored; acceptance begins from the first edge with rst=1 already stable.

Structure
REQ-025 Package uart_tx_pkg SHALL hold the state encoding and the DATA_WIDTH default.
REQ-026 One sub-module uart_tx_serializer (load, shift, bit counter, last-bit flag) SHALL be instantiated; the FSM stays in uart_tx_ctrl.
REQ-027 The parity block remains external; uart_tx_ctrl SHALL NOT recompute parity.

Verification
REQ-028 p_data=0xA5, par_en=1, par_typ=0 (par_bit=0) -> tx_out 0,1,0,1,0,0,1,0,1,0,1; busy high for 11 cycles.
REQ-029 p_data=0x00, par_en=1, par_typ=1 (par_bit=1) -> tx_out 0, eight 0s, 1, 1; parity cycle shows 1.
REQ-030 p_data=0xFF, par_en=0 -> tx_out 0, eight 1s, 1; busy high exactly 10 cycles, then IDLE.
REQ-031 0x3C then 0xC3 accepted in the STOP cycle -> second start bit immediately follows the stop bit; busy never drops between frames.
REQ-032 data_valid pulsed with 0x55 during DATA of a 0x0F frame -> 0x0F frame unchanged; 0x55 never transmitted.
REQ-033 rst=0 during DATA bit 3 of 0x81 -> tx_out=1 and busy=0 asynchronously; a later 0x42 transmits as a clean full frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared state encoding, default payload width and a counter
//               width helper for the UART transmit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  // Default number of payload bits per frame.
  localparam int c_DATA_WIDTH = 8;

  // Frame state encoding; values outside this set are treated as illegal.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Width of a counter that must reach w-1 (never less than one bit).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_serializer
// Description : Payload shift register with bit counter. Presents the bit on
//               the line now, the bit that follows it, and a last-bit flag.
// Revision    : 1.0 - initial release
// ============================================================================
import uart_tx_pkg::*;

module uart_tx_serializer #(
  parameter int DATA_WIDTH = c_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  bit_cur,
  output logic                  bit_next,
  output logic                  last
);

  localparam int                 c_CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [c_CNT_W-1:0]    r_cnt;

  // Load a fresh payload with the counter at bit 0, or step to the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_shift <= data_in;
      r_cnt   <= '0;
    end else if (shift) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + c_ONE;
    end
  end

  assign bit_cur = r_shift[0];
  assign last    = (r_cnt == c_LAST);

  // The look-ahead bit only exists for payloads wider than one bit; with a
  // single bit the last flag is always set, so bit_next is never consumed.
  generate
    if (DATA_WIDTH > 1) begin : g_next_wide
      assign bit_next = r_shift[1];
    end else begin : g_next_narrow
      assign bit_next = r_shift[0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_ctrl
// Description : UART transmit frame controller. Sends start, LSB-first data,
//               optional externally computed parity, and stop bit. tx_out and
//               busy are registered from the next state so the start bit is
//               on the line in the cycle right after the accepting edge.
// Revision    : 1.0 - initial release
// ============================================================================
import uart_tx_pkg::*;

module uart_tx_ctrl #(
  parameter int DATA_WIDTH = c_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  par_bit,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_t r_state;
  tx_state_t w_next_state;

  logic r_armed;
  logic r_par_bit;
  logic r_par_en;
  logic r_par_typ;

  logic w_accept;
  logic w_load;
  logic w_shift;
  logic w_tx_next;
  logic w_busy_next;
  logic w_bit_cur;
  logic w_bit_next;
  logic w_last;

  // A request is honoured only once reset has been released for a full edge,
  // so a data_valid coinciding with reset release is dropped.
  assign w_accept = data_valid & r_armed;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .shift    (w_shift),
    .data_in  (p_data),
    .bit_cur  (w_bit_cur),
    .bit_next (w_bit_next),
    .last     (w_last)
  );

  // Arm acceptance on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus the line level and busy flag for the coming cycle.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_tx_next    = 1'b1;
    w_busy_next  = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_START;
          w_load       = 1'b1;
          w_tx_next    = 1'b0;
        end else begin
          w_busy_next  = 1'b0;
        end
      end
      ST_START: begin
        w_next_state = ST_DATA;
        w_tx_next    = w_bit_cur;
      end
      ST_DATA: begin
        if (w_last) begin
          if (r_par_en) begin
            w_next_state = ST_PARITY;
            w_tx_next    = r_par_bit;
          end else begin
            w_next_state = ST_STOP;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_shift   = 1'b1;
          w_tx_next = w_bit_next;
        end
      end
      ST_PARITY: begin
        w_next_state = ST_STOP;
        w_tx_next    = 1'b1;
      end
      ST_STOP: begin
        if (w_accept) begin
          w_next_state = ST_START;
          w_load       = 1'b1;
          w_tx_next    = 1'b0;
        end else begin
          w_next_state = ST_IDLE;
          w_busy_next  = 1'b0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_tx_next    = 1'b1;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // Capture parity and frame configuration alongside the payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_load) begin
      r_par_bit <= par_bit;
      r_par_en  <= par_en;
      r_par_typ <= par_typ;
    end
  end

  // Registered line driver and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_out <= 1'b1;
      busy   <= 1'b0;
    end else begin
      tx_out <= w_tx_next;
      busy   <= w_busy_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_ctrl
// Description : Directed self-checking bench for uart_tx_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic       par_bit = 1'b0;
  logic       tx_out;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_ctrl #(
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .par_bit    (par_bit),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic set_req(input logic [7:0] d, input logic pen, input logic ptyp,
                         input logic par);
    p_data     = d;
    par_en     = pen;
    par_typ    = ptyp;
    par_bit    = par;
    data_valid = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, "_tx"}, tx_out, 1'b1);
    chk_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  // Expects the request to be pending at the next posedge. After acceptance
  // the live inputs are scrambled so use of unlatched values shows up.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic par, input int inject_at, input logic chain,
                           input logic [7:0] nd, input logic npen, input logic nptyp,
                           input logic npar);
    logic [10:0] exp;
    int          len;
    exp = '1;
    exp[0] = 1'b0;
    for (int k = 0; k < 8; k++) exp[k+1] = d[k];
    if (pen) exp[9] = par;
    len = pen ? 11 : 10;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      chk_eq($sformatf("%s_tx[%0d]", tag, i), tx_out, exp[i]);
      chk_eq($sformatf("%s_busy[%0d]", tag, i), busy, 1'b1);
      if (i == 0) begin
        data_valid = 1'b0;
        p_data     = ~d;
        par_bit    = ~par;
      end
      if (i == inject_at) set_req(8'h55, 1'b1, 1'b0, 1'b0);
      if (inject_at >= 0 && i == inject_at + 1) begin
        data_valid = 1'b0;
        par_bit    = ~par;
      end
      if (i == len - 1 && chain) set_req(nd, npen, nptyp, npar);
    end
    if (!chain) begin
      @(posedge clk);
      #1;
      chk_idle({tag, "_end"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    chk_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("post_reset");

    // 0xA5 even parity (bit 0) -> 0,1,0,1,0,0,1,0,1,0,1
    set_req(8'hA5, 1'b1, 1'b0, 1'b0);
    run_frame("a5", 8'hA5, 1'b1, 1'b0, -1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 0x00 odd parity (bit 1)
    @(negedge clk);
    set_req(8'h00, 1'b1, 1'b1, 1'b1);
    run_frame("z00", 8'h00, 1'b1, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 0xFF without parity, 10-cycle frame
    @(negedge clk);
    set_req(8'hFF, 1'b0, 1'b0, 1'b0);
    run_frame("ff", 8'hFF, 1'b0, 1'b0, -1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 0x3C then 0xC3 back to back, second accepted in the STOP cycle
    @(negedge clk);
    set_req(8'h3C, 1'b1, 1'b0, 1'b0);
    run_frame("b2b1", 8'h3C, 1'b1, 1'b0, -1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b1);
    run_frame("b2b2", 8'hC3, 1'b1, 1'b1, -1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // 0x0F with a 0x55 request pulsed during its data bits
    @(negedge clk);
    set_req(8'h0F, 1'b1, 1'b0, 1'b0);
    run_frame("ign", 8'h0F, 1'b1, 1'b0, 3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_idle("ign_after");
    end

    // 0x81 aborted by reset during data bit 3
    @(negedge clk);
    set_req(8'h81, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_eq($sformatf("abort_tx[%0d]", i), tx_out, (i == 0) ? 1'b0 : (i == 1) ? 1'b1 : 1'b0);
      if (i == 0) data_valid = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk_idle("abort_async");
    repeat (2) @(negedge clk);
    chk_idle("abort_hold");

    // Request coinciding with reset release must be dropped
    rst = 1'b1;
    set_req(8'h42, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_idle("rel_ignore");
    data_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_idle("rel_quiet");
    end

    // Clean 0x42 frame after the abort
    @(negedge clk);
    set_req(8'h42, 1'b1, 1'b0, 1'b0);
    run_frame("x42", 8'h42, 1'b1, 1'b0, -1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
